// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator.
// Imported by the address decoder and the apb_master top.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam logic [15:0] APB_BASE_HI    = 16'h1000;
  localparam int          APB_MAX_SLAVES = 16;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational request-address decoder for the APB initiator.
// Produces hit, slave index addr[15:12] and a one-hot select.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = APB_BASE_HI
) (
  input  logic [31:0]           i_addr,
  output logic                  o_hit,
  output logic [3:0]            o_idx,
  output logic [NUM_SLAVES-1:0] o_sel
);

  localparam int NS =
    (NUM_SLAVES > APB_MAX_SLAVES) ? APB_MAX_SLAVES : NUM_SLAVES;
  localparam logic [4:0] NS_W = 5'(NS);

  logic w_base_ok;
  logic w_idx_ok;
  logic w_unused;

  // Byte offset inside a slave window plays no part in selection
  assign w_unused  = ^i_addr[11:0];
  assign w_base_ok = (i_addr[31:16] == BASE_HI);
  assign w_idx_ok  = ({1'b0, i_addr[15:12]} < NS_W);
  assign o_hit     = w_base_ok && w_idx_ok;
  assign o_idx     = i_addr[15:12];

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NS; i++) begin
      o_sel[i] = o_hit && (o_idx == 4'(i));
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: one outstanding request, SETUP/ACCESS sequencing.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [15:0] BASE_HI        = APB_BASE_HI,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        transfer,
  input  logic                        write,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 wdata,
  output logic [31:0]                 rdata,
  output logic                        ready,
  output logic                        err,
  output logic                        busy,
  output logic [31:0]                 PADDR,
  output logic                        PWRITE,
  output logic [31:0]                 PWDATA,
  output logic                        PENABLE,
  output logic [NUM_SLAVES-1:0]       PSEL,
  input  logic [NUM_SLAVES-1:0][31:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]       PREADY
);

  apb_state_e r_state;
  apb_state_e w_next;

  logic [31:0]           r_paddr;
  logic                  r_pwrite;
  logic [31:0]           r_pwdata;
  logic                  r_hit;
  logic [3:0]            r_idx;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_err;

  logic                  w_hit;
  logic [3:0]            w_idx;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_latch;
  logic                  w_done;
  logic                  w_err;
  logic [31:0]           w_rdata;
  logic [31:0]           w_prdata;
  logic                  w_pready;
  logic                  w_tmo;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_HI    (BASE_HI)
  ) u_dec (
    .i_addr (addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_sel  (w_sel)
  );

  // Only the latched slave is ever looked at
  always_comb begin
    w_prdata = '0;
    w_pready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == 4'(i)) begin
        w_prdata = PRDATA[i];
        w_pready = PREADY[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  assign w_tmo = (r_cnt == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS && !w_pready) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  logic [15:0] w_unused_tmo;

  assign w_unused_tmo = 16'(TIMEOUT_CYCLES);
  assign w_tmo        = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_rdata = '0;
    unique case (r_state)
      IDLE: begin
        if (transfer) begin
          w_latch = 1'b1;
          w_next  = SETUP;
        end
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        if (!r_hit) begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end else if (w_pready) begin
          w_done  = 1'b1;
          w_rdata = r_pwrite ? 32'd0 : w_prdata;
        end else if (w_tmo) begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end
        if (w_done) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_hit    <= 1'b0;
      r_idx    <= '0;
      r_sel    <= '0;
    end else if (w_latch) begin
      r_paddr  <= addr;
      r_pwrite <= write;
      r_pwdata <= wdata;
      r_hit    <= w_hit;
      r_idx    <= w_idx;
      r_sel    <= w_sel;
    end
  end

  // Completion outputs are single-cycle pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= w_rdata;
      r_ready <= w_done;
      r_err   <= w_err;
    end
  end

  assign busy    = (r_state != IDLE);
  assign PENABLE = (r_state == ACCESS);
  assign PSEL    = busy ? r_sel : '0;
  assign PADDR   = r_paddr;
  assign PWRITE  = r_pwrite;
  assign PWDATA  = r_pwdata;
  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign err     = r_err;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with behavioural APB slaves.
// Expectations for the watchdog follow APB_TIMEOUT_EN.
module tb_apb_master;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              transfer = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic              PENABLE;
  logic [3:0]        PSEL;
  logic [3:0][31:0]  PRDATA;
  logic [3:0]        PREADY;

  int n_checks = 0;
  int n_errors = 0;

  apb_master #(
    .NUM_SLAVES     (4),
    .BASE_HI        (16'h1000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .busy     (busy),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  always #5 i_clk = ~i_clk;

  // Slave model: per-slave wait states, word memory with default pattern
  int          waits [4];
  int          acc_cnt = 0;
  logic [31:0] mem [4][16];
  bit          wv [4][16];

  always @(posedge i_clk) begin
    acc_cnt <= (PENABLE && !(|PREADY)) ? acc_cnt + 1 : 0;
    for (int s = 0; s < 4; s++) begin
      if (PSEL[s] && PENABLE && PREADY[s] && PWRITE) begin
        mem[s][PADDR[5:2]] <= PWDATA;
        wv[s][PADDR[5:2]]  <= 1'b1;
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    PREADY = '0;
    for (int s = 0; s < 4; s++) begin
      PRDATA[s] = wv[s][PADDR[5:2]] ? mem[s][PADDR[5:2]] :
                  (32'h5000_0000 | 32'(s * 256) | {28'd0, PADDR[5:2]});
      PREADY[s] = PSEL[s] && PENABLE && (acc_cnt >= waits[s]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, output int lat,
                      output logic [3:0] ps, output logic [31:0] rd,
                      output logic er);
    @(negedge i_clk);
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    @(posedge i_clk);
    #1;
    transfer = 1'b0;
    lat = -1;
    ps  = PSEL;
    rd  = '0;
    er  = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge i_clk);
      #1;
      ps = ps | PSEL;
      if (ready) begin
        lat = n;
        rd  = rdata;
        er  = err;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic [3:0]  psel;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [9];

  initial begin
    int          lat;
    logic [3:0]  ps;
    logic [31:0] rd;
    logic        er;
    int          pulses;
    int          paddr_bad;

    waits[0] = 0;
    waits[1] = 0;
    waits[2] = 2;
    waits[3] = 1;

    tv[0] = '{1'b1, 32'h1000_3004, 32'hDEAD_BEEF, 3, 4'b1000, 1'b0, 32'h0};
    tv[1] = '{1'b0, 32'h1000_3004, 32'h0000_0000, 3, 4'b1000, 1'b0, 32'hDEAD_BEEF};
    tv[2] = '{1'b0, 32'h2000_0000, 32'h0000_0011, 2, 4'b0000, 1'b1, 32'h0};
    tv[3] = '{1'b1, 32'h1000_0010, 32'h1234_5678, 2, 4'b0001, 1'b0, 32'h0};
    tv[4] = '{1'b0, 32'h1000_0010, 32'h0000_0022, 2, 4'b0001, 1'b0, 32'h1234_5678};
    tv[5] = '{1'b0, 32'h1000_4000, 32'h0000_0033, 2, 4'b0000, 1'b1, 32'h0};
    tv[6] = '{1'b1, 32'h1000_2008, 32'hA5A5_5A5A, 4, 4'b0100, 1'b0, 32'h0};
    tv[7] = '{1'b0, 32'h1000_2008, 32'h0000_0044, 4, 4'b0100, 1'b0, 32'hA5A5_5A5A};
    tv[8] = '{1'b0, 32'h1000_0004, 32'h0000_0055, 2, 4'b0001, 1'b0, 32'h5000_0001};

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_psel",   32'(PSEL), 32'h0);
    chk("rst_pen",    32'(PENABLE), 32'h0);
    chk("rst_paddr",  PADDR, 32'h0);
    chk("rst_pwrite", 32'(PWRITE), 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rdata",  rdata, 32'h0);
    chk("rst_flags",  {29'd0, ready, err, busy}, 32'h0);
    i_rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      xfer(tv[i].w, tv[i].a, tv[i].d, lat, ps, rd, er);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_psel", i), 32'(ps), 32'(tv[i].psel));
      chk($sformatf("v%0d_err", i), 32'(er), 32'(tv[i].e));
      chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d_pwrite", i), 32'(PWRITE), 32'(tv[i].w));
      chk($sformatf("v%0d_paddr", i), PADDR, tv[i].a);
      chk($sformatf("v%0d_pwdata", i), PWDATA, tv[i].d);
      chk($sformatf("v%0d_sel_drop", i), {28'd0, PSEL}, 32'h0);
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_pulse", i), {30'd0, ready, busy}, 32'h0);
    end

    // Slow slave 1 with a stray request during ACCESS
    waits[1] = 5;
    @(negedge i_clk);
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_1008;
    wdata    = 32'h0BAD_0BAD;
    @(posedge i_clk);
    #1;
    transfer  = 1'b0;
    lat       = -1;
    pulses    = 0;
    paddr_bad = 0;
    rd        = '0;
    for (int n = 1; n <= 12; n++) begin
      if (n == 3) begin
        transfer = 1'b1;
        write    = 1'b1;
        addr     = 32'h1000_0000;
        wdata    = 32'hFFFF_FFFF;
      end else begin
        transfer = 1'b0;
      end
      @(posedge i_clk);
      #1;
      if (PADDR !== 32'h1000_1008) paddr_bad++;
      if (ready) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          rd  = rdata;
        end
      end
    end
    transfer = 1'b0;
    chk("slow_lat",    32'(lat), 32'd7);
    chk("slow_pulses", 32'(pulses), 32'd1);
    chk("slow_paddr",  32'(paddr_bad), 32'd0);
    chk("slow_rdata",  rd, 32'h5000_0102);
    chk("slow_pwrite", 32'(PWRITE), 32'h0);
    chk("slow_idle",   32'(busy), 32'h0);

    // Slave 2 never answers
    waits[2] = 1000;
    xfer(1'b0, 32'h1000_2000, 32'h0, lat, ps, rd, er);
`ifdef APB_TIMEOUT_EN
    chk("tmo_lat",   32'(lat), 32'd17);
    chk("tmo_err",   32'(er), 32'h1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_psel",  32'(ps), 32'h4);
    @(posedge i_clk);
    #1;
    chk("tmo_idle",  {30'd0, ready, busy}, 32'h0);
`else
    chk("hang_lat",  32'(lat), 32'hFFFF_FFFF);
    chk("hang_busy", {30'd0, busy, PENABLE}, 32'h3);
    chk("hang_psel", 32'(PSEL), 32'h4);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("hang_rst",  32'(busy), 32'h0);
`endif
    waits[2] = 2;

    // Reset in the middle of an ACCESS
    waits[0] = 3;
    @(negedge i_clk);
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_0004;
    wdata    = 32'h0;
    @(posedge i_clk);
    #1;
    transfer = 1'b0;
    @(posedge i_clk);
    #1;
    chk("mid_pen", {27'd0, PSEL, PENABLE}, 32'h3);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("mid_psel",  32'(PSEL), 32'h0);
    chk("mid_flags", {29'd0, PENABLE, busy, ready}, 32'h0);
    chk("mid_paddr", PADDR, 32'h0);
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge i_clk);
      #1;
      if (ready || busy) pulses++;
    end
    chk("mid_quiet", 32'(pulses), 32'd0);
    xfer(1'b0, 32'h1000_0004, 32'h0, lat, ps, rd, er);
    chk("post_lat",   32'(lat), 32'd5);
    chk("post_rdata", rd, 32'h5000_0001);
    chk("post_err",   32'(er), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
